// File: rtl/game_pkg.sv
// Shared definitions for the typing-game sequencer and the count/score datapath:
// state encodings, keyboard scan codes and the round-length value tables.
package game_pkg;

    typedef enum logic [1:0] {
        SELECT    = 2'd0,
        COUNTDOWN = 2'd1,
        INGAME    = 2'd2,
        FINISH    = 2'd3
    } game_state_t;

    localparam logic [8:0] KEY_ENTER = 9'd90;
    localparam logic [8:0] KEY_ESC   = 9'd118;
    localparam logic [8:0] KEY_SPACE = 9'd41;
    localparam logic [8:0] KEY_M     = 9'd58;
    localparam logic [8:0] KEY_J     = 9'd59;
    localparam logic [8:0] KEY_K     = 9'd66;

    // One-hot menu actions; at most one bit is set in any cycle.
    typedef struct packed {
        logic enter;
        logic esc;
        logic space;
        logic m;
        logic j;
        logic k;
    } key_act_t;

    // Entry [0] is the rightmost element: TIME_TAB[sel] gives seconds, WORD_TAB[sel] gives words.
    localparam logic [3:0][6:0] TIME_TAB = {7'd120, 7'd60, 7'd30, 7'd15};
    localparam logic [3:0][6:0] WORD_TAB = {7'd100, 7'd50, 7'd25, 7'd10};

endpackage

// File: rtl/game_ctrl_if.sv
// Keyboard/datapath-facing signal bundle of the game sequencer.
// slave is the sequencer side; master is the side that drives keys and finish.
interface game_ctrl_if import game_pkg::*; ();

    logic         key_valid;
    logic [127:0] key_down;
    logic [8:0]   last_change;
    logic         finish;

    game_state_t  state;
    logic         mode;
    logic [6:0]   value;
    logic [1:0]   cd_sec;
    logic         start_pulse;

    modport master (
        output key_valid, key_down, last_change, finish,
        input  state, mode, value, cd_sec, start_pulse
    );

    modport slave (
        input  key_valid, key_down, last_change, finish,
        output state, mode, value, cd_sec, start_pulse
    );

endinterface

// File: rtl/game_ctrl_key_press_edge.sv
// Turns PS/2 decoder events into single-cycle menu actions; held keys and
// break codes never re-fire because the previous key level is remembered.
module key_press_edge import game_pkg::*; (
    input  logic         clk,
    input  logic         rst,
    input  logic         key_valid,
    input  logic [127:0] key_down,
    input  logic [8:0]   last_change,
    output key_act_t     act
);

    logic level;
    logic prev;
    logic press;

    // Scan codes beyond the 128-entry bitmap can never be reported as held.
    always_comb begin
        level = 1'b0;
        if (last_change[8:7] == 2'b00)
            level = key_down[last_change[6:0]];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            prev <= 1'b0;
        else
            prev <= level;
    end

    assign press = key_valid & level & ~prev;

    always_comb begin
        act       = '0;
        act.enter = press && (last_change == KEY_ENTER);
        act.esc   = press && (last_change == KEY_ESC);
        act.space = press && (last_change == KEY_SPACE);
        act.m     = press && (last_change == KEY_M);
        act.j     = press && (last_change == KEY_J);
        act.k     = press && (last_change == KEY_K);
    end

endmodule

// File: rtl/game_ctrl.sv
// Typing-game sequencer: menu selection, 3-2-1 countdown, round start/end,
// and the mode/value configuration consumed by the scoring datapath.
module game_ctrl import game_pkg::*; #(
    parameter int unsigned TICK_DIV = 10_000_000,
    parameter int unsigned CD_TICKS = 30
) (
    input logic        clk,
    input logic        rst,
    game_ctrl_if.slave bus
);

    localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned CW = (CD_TICKS > 1) ? $clog2(CD_TICKS + 1) : 1;

    key_act_t    act;
    game_state_t state_q, state_d;
    logic        mode_q, mode_d;
    logic [1:0]  sel_q, sel_d;
    logic [6:0]  value_q;
    logic        start_q, start_d;
    logic        cd_clear;
    logic        tick;
    logic        cd_last;
    logic [TW-1:0] tick_cnt;
    logic [CW-1:0] cd_cnt;

    key_press_edge u_key (
        .clk         (clk),
        .rst         (rst),
        .key_valid   (bus.key_valid),
        .key_down    (bus.key_down),
        .last_change (bus.last_change),
        .act         (act)
    );

    assign tick    = (state_q == COUNTDOWN) && (tick_cnt == TW'(TICK_DIV - 1));
    assign cd_last = (cd_cnt == CW'(CD_TICKS - 1));

    // ESC is checked first in every in-round state so it overrides tick and finish.
    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        sel_d    = sel_q;
        start_d  = 1'b0;
        cd_clear = 1'b0;
        unique case (state_q)
            SELECT: begin
                if (act.m)
                    mode_d = ~mode_q;
                else if (act.k && (sel_q != 2'd3))
                    sel_d = sel_q + 2'd1;
                else if (act.j && (sel_q != 2'd0))
                    sel_d = sel_q - 2'd1;
                else if (act.enter) begin
                    state_d  = COUNTDOWN;
                    cd_clear = 1'b1;
                end
            end
            COUNTDOWN: begin
                if (act.esc)
                    state_d = SELECT;
                else if (tick && cd_last) begin
                    state_d = INGAME;
                    start_d = 1'b1;
                end
            end
            INGAME: begin
                if (act.esc)
                    state_d = SELECT;
                else if (bus.finish)
                    state_d = FINISH;
            end
            FINISH: begin
                if (act.esc || act.enter)
                    state_d = SELECT;
                else if (act.space) begin
                    state_d  = COUNTDOWN;
                    cd_clear = 1'b1;
                end
            end
            default: state_d = SELECT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= SELECT;
            mode_q  <= 1'b0;
            sel_q   <= 2'd1;
            value_q <= TIME_TAB[1];
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            sel_q   <= sel_d;
            value_q <= mode_q ? WORD_TAB[sel_q] : TIME_TAB[sel_q];
            start_q <= start_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_cnt <= '0;
            cd_cnt   <= '0;
        end else begin
            if ((state_q != COUNTDOWN) || tick)
                tick_cnt <= '0;
            else
                tick_cnt <= tick_cnt + TW'(1);

            if (cd_clear)
                cd_cnt <= '0;
            else if (tick)
                cd_cnt <= cd_cnt + CW'(1);
        end
    end

    assign bus.state       = state_q;
    assign bus.mode        = mode_q;
    assign bus.value       = value_q;
    assign bus.start_pulse = start_q;
    assign bus.cd_sec      = (state_q == COUNTDOWN) ? 2'(3 - int'(cd_cnt) / 10) : 2'd0;

endmodule

// File: tb/tb_game_ctrl.sv
// Self-checking bench for game_ctrl: directed menu/countdown/abort scenarios
// followed by random key traffic, all compared against a cycle reference model.
module tb_game_ctrl;

    localparam int TD = 4;
    localparam int CT = 30;

    localparam int C_ENTER = 90;
    localparam int C_ESC   = 118;
    localparam int C_SPACE = 41;
    localparam int C_M     = 58;
    localparam int C_J     = 59;
    localparam int C_K     = 66;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    game_ctrl_if bus ();

    game_ctrl #(.TICK_DIV(TD), .CD_TICKS(CT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int pulses  = 0;

    // Reference model state, expressed as elapsed cycles rather than counters.
    int m_state, m_mode, m_sel, m_value, m_elapsed, m_start;
    bit m_prev;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int tab(input int mode, input int sel);
        int tt[4];
        int wt[4];
        tt = '{15, 30, 60, 120};
        wt = '{10, 25, 50, 100};
        return mode ? wt[sel] : tt[sel];
    endfunction

    task automatic m_reset();
        m_state   = 0;
        m_mode    = 0;
        m_sel     = 1;
        m_value   = 30;
        m_elapsed = 0;
        m_start   = 0;
        m_prev    = 1'b0;
    endtask

    function automatic int m_cd();
        return (m_state == 1) ? 3 - (m_elapsed / TD) / 10 : 0;
    endfunction

    task automatic model_edge();
        bit lvl;
        bit pr;
        int lc;
        if (rst) begin
            m_reset();
            return;
        end
        lc = int'(bus.last_change);
        lvl = (lc < 128) ? bus.key_down[lc] : 1'b0;
        pr = bus.key_valid && lvl && !m_prev;
        m_prev = lvl;
        m_value = tab(m_mode, m_sel);
        m_start = 0;
        case (m_state)
            0: if (pr) begin
                if (lc == C_M) m_mode = 1 - m_mode;
                else if (lc == C_K) m_sel = (m_sel < 3) ? m_sel + 1 : 3;
                else if (lc == C_J) m_sel = (m_sel > 0) ? m_sel - 1 : 0;
                else if (lc == C_ENTER) begin
                    m_state = 1;
                    m_elapsed = 0;
                end
            end
            1: begin
                if (pr && lc == C_ESC) m_state = 0;
                else if (m_elapsed + 1 == TD * CT) begin
                    m_state = 2;
                    m_start = 1;
                end else m_elapsed++;
            end
            2: begin
                if (pr && lc == C_ESC) m_state = 0;
                else if (bus.finish) m_state = 3;
            end
            default: if (pr) begin
                if (lc == C_ESC || lc == C_ENTER) m_state = 0;
                else if (lc == C_SPACE) begin
                    m_state = 1;
                    m_elapsed = 0;
                end
            end
        endcase
    endtask

    task automatic compare_all();
        check("state", 32'(bus.state), m_state);
        check("mode", 32'(bus.mode), m_mode);
        check("value", 32'(bus.value), m_value);
        check("cd_sec", 32'(bus.cd_sec), m_cd());
        check("start_pulse", 32'(bus.start_pulse), m_start);
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        cyc++;
        if (bus.start_pulse === 1'b1) pulses++;
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic ev(input int code, input bit down);
        bus.key_down[code] = down;
        bus.key_valid      = 1'b1;
        bus.last_change    = 9'(code);
        step();
        bus.key_valid      = 1'b0;
    endtask

    task automatic tap(input int code);
        ev(code, 1'b1);
        ev(code, 1'b0);
    endtask

    task automatic wait_state(input int target, input string tag);
        int guard;
        guard = 0;
        while (bus.state !== 2'(target) && guard < 300) begin
            step();
            guard++;
        end
        if (guard >= 300) check(tag, 32'(bus.state), target);
    endtask

    initial begin
        int t0;
        int keys[7];
        keys = '{C_ENTER, C_SPACE, C_M, C_J, C_K, 28, 50};

        rst             = 1'b1;
        bus.key_valid   = 1'b0;
        bus.key_down    = '0;
        bus.last_change = '0;
        bus.finish      = 1'b0;
        m_reset();
        idle(3);
        check("reset_value", 32'(bus.value), 30);
        rst = 1'b0;
        idle(2);

        // Selection saturates at the top entry, then mode flips the table.
        repeat (4) tap(C_K);
        check("sat_time_value", 32'(bus.value), 120);
        tap(C_M);
        step();
        check("sat_word_value", 32'(bus.value), 100);
        check("sat_mode", 32'(bus.mode), 1);

        // Countdown length and single start pulse.
        pulses = 0;
        ev(C_ENTER, 1'b1);
        t0 = cyc;
        check("enter_state", 32'(bus.state), 1);
        check("cd_first_digit", 32'(bus.cd_sec), 3);
        ev(C_ENTER, 1'b0);
        wait_state(2, "countdown_timeout");
        check("cd_to_ingame", cyc - t0, TD * CT);
        idle(3);
        check("start_pulse_count", pulses, 1);

        // Finish, replay, and return to the menu.
        bus.finish = 1'b1;
        step();
        bus.finish = 1'b0;
        check("finish_state", 32'(bus.state), 3);
        tap(C_SPACE);
        check("replay_state", 32'(bus.state), 1);
        check("replay_value", 32'(bus.value), 100);
        wait_state(2, "replay_timeout");
        bus.finish = 1'b1;
        ev(C_ENTER, 1'b1);
        bus.finish = 1'b0;
        check("finish_beats_enter", 32'(bus.state), 3);
        ev(C_ENTER, 1'b0);
        tap(C_ENTER);
        check("finish_enter_select", 32'(bus.state), 0);

        // Auto-repeat of a held key counts once.
        tap(C_J);
        tap(C_J);
        step();
        check("j_down_value", 32'(bus.value), 25);
        ev(C_K, 1'b1);
        repeat (4) ev(C_K, 1'b1);
        ev(C_K, 1'b0);
        step();
        check("held_k_value", 32'(bus.value), 50);

        // ESC mid-countdown, menu keys frozen in-round, ESC over finish.
        ev(C_ENTER, 1'b1);
        t0 = cyc;
        ev(C_ENTER, 1'b0);
        while (cyc - t0 < 60) step();
        check("cd_mid_digit", 32'(bus.cd_sec), 2);
        tap(C_ESC);
        check("esc_countdown", 32'(bus.state), 0);
        tap(C_ENTER);
        wait_state(2, "ingame_timeout");
        tap(C_J);
        tap(C_K);
        tap(C_M);
        step();
        check("frozen_mode", 32'(bus.mode), 1);
        check("frozen_value", 32'(bus.value), 50);
        bus.finish = 1'b1;
        ev(C_ESC, 1'b1);
        bus.finish = 1'b0;
        check("esc_over_finish", 32'(bus.state), 0);
        ev(C_ESC, 1'b0);

        // Asynchronous reset mid-countdown, observed between clock edges.
        tap(C_ENTER);
        idle(20);
        #2;
        rst = 1'b1;
        #1;
        m_reset();
        check("arst_state", 32'(bus.state), 0);
        check("arst_value", 32'(bus.value), 30);
        check("arst_mode", 32'(bus.mode), 0);
        check("arst_cd_sec", 32'(bus.cd_sec), 0);
        step();
        rst = 1'b0;
        idle(2);

        // Random key traffic with occasional finish.
        for (int i = 0; i < 3000; i++) begin
            int code;
            int idx;
            bus.finish = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 99) < 25) begin
                idx = $urandom_range(0, 15);
                code = (idx == 0) ? C_ESC : keys[idx % 7];
                if (bus.key_down[code] && $urandom_range(0, 9) < 6)
                    ev(code, 1'b0);
                else
                    ev(code, 1'b1);
            end else begin
                step();
            end
        end
        bus.finish = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
